// File: rtl/cam_match_sequencer.sv
// Serialises a multi-hot CAM match vector into one encoded address per beat.
// Optional CAM_MATCH_COUNT_EN latches the popcount of each accepted vector.
module cam_match_sequencer #(
  parameter int    WIDTH        = 16,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       match_valid,
  output logic                       match_ready,
  input  logic [WIDTH-1:0]           match_vector,
  input  logic                       flush,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [$clog2(WIDTH)-1:0]   addr_out,
  output logic                       addr_last,
  output logic                       no_match,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] match_count
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 1 << AW;
  localparam bit HIGH_FIRST = (LSB_PRIORITY == "HIGH");

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic             no_match_reg, no_match_next;
  logic [PW-1:0]    padded;
  logic [AW-1:0]    enc;
  logic             one_left;

  // Encoder sees a power-of-two input; the padded tail is hard-wired to zero.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_pad
      if (gi < WIDTH) begin : g_live
        assign padded[gi] = pending_reg[gi];
      end else begin : g_zero
        assign padded[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    enc = '0;
    if (HIGH_FIRST) begin
      for (int i = PW - 1; i >= 0; i--)
        if (padded[i]) enc = AW'(i);
    end else begin
      for (int i = 0; i < PW; i++)
        if (padded[i]) enc = AW'(i);
    end
  end

  assign one_left = (pending_reg != '0) &&
                    ((pending_reg & (pending_reg - WIDTH'(1))) == '0);

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    no_match_next = 1'b0;
    match_ready   = 1'b0;
    addr_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        match_ready = 1'b1;
        if (match_valid && !flush) begin
          if (match_vector != '0) begin
            pending_next = match_vector;
            state_next   = EMIT;
          end else begin
            no_match_next = 1'b1;
          end
        end
      end
      EMIT: begin
        addr_valid = 1'b1;
        if (addr_ready) begin
          pending_next = pending_reg & ~(WIDTH'(1) << enc);
          if (one_left) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A flush overrides any acceptance or handshake in the same cycle.
    if (flush) begin
      state_next    = IDLE;
      pending_next  = '0;
      no_match_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      no_match_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      no_match_reg <= no_match_next;
    end
  end

  assign addr_out  = addr_valid ? enc : '0;
  assign addr_last = addr_valid & one_left;
  assign no_match  = no_match_reg;
  assign busy      = (state_reg != IDLE);

`ifdef CAM_MATCH_COUNT_EN
  logic          accept;
  logic [CW-1:0] popcnt;
  logic [CW-1:0] count_reg;

  assign accept = (state_reg == IDLE) && match_valid && !flush;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++)
      popcnt = popcnt + CW'(match_vector[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= popcnt;
    end
  end

  assign match_count = count_reg;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_cam_match_sequencer.sv
// Scoreboard bench: a WIDTH=16/LOW instance and a WIDTH=12/HIGH instance.
module tb_cam_match_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, addr_ready;

  logic        a_valid, a_ready, a_addr_valid, a_last, a_nomatch, a_busy;
  logic [15:0] a_vec;
  logic [3:0]  a_addr;
  logic [4:0]  a_cnt;

  logic        b_valid, b_ready, b_addr_valid, b_last, b_nomatch, b_busy;
  logic [11:0] b_vec;
  logic [3:0]  b_addr;
  logic [3:0]  b_cnt;

  cam_match_sequencer #(.WIDTH(16), .LSB_PRIORITY("LOW")) dut_a (
    .clk(clk), .rst_n(rst_n), .match_valid(a_valid), .match_ready(a_ready),
    .match_vector(a_vec), .flush(flush), .addr_valid(a_addr_valid),
    .addr_ready(addr_ready), .addr_out(a_addr), .addr_last(a_last),
    .no_match(a_nomatch), .busy(a_busy), .match_count(a_cnt));

  cam_match_sequencer #(.WIDTH(12), .LSB_PRIORITY("HIGH")) dut_b (
    .clk(clk), .rst_n(rst_n), .match_valid(b_valid), .match_ready(b_ready),
    .match_vector(b_vec), .flush(flush), .addr_valid(b_addr_valid),
    .addr_ready(addr_ready), .addr_out(b_addr), .addr_last(b_last),
    .no_match(b_nomatch), .busy(b_busy), .match_count(b_cnt));

  int errors = 0;
  int checks = 0;
  int qa[$];
  int qb[$];
  int cnt_a = 0;
  int cnt_b = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_count(input logic [15:0] v);
`ifdef CAM_MATCH_COUNT_EN
    return $countones(v);
`else
    return (v == 16'h0) ? 0 : 0;
`endif
  endfunction

  task automatic model_push(input bit sel, input logic [15:0] v);
    int lst[$];
    if (!sel) begin
      for (int i = 15; i >= 0; i--) if (v[i]) lst.push_back(i);
    end else begin
      for (int i = 0; i < 12; i++) if (v[i]) lst.push_back(i);
    end
    for (int k = 0; k < lst.size(); k++) begin
      if (!sel) qa.push_back(lst[k] * 2 + ((k == lst.size() - 1) ? 1 : 0));
      else      qb.push_back(lst[k] * 2 + ((k == lst.size() - 1) ? 1 : 0));
    end
    if (!sel) cnt_a = exp_count(v);
    else      cnt_b = exp_count(v & 16'h0FFF);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit sel, input logic [15:0] v);
    bit got = 1'b0;
    bit rdy;
    if (!sel) begin a_valid = 1'b1; a_vec = v; end
    else      begin b_valid = 1'b1; b_vec = v[11:0]; end
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      rdy = sel ? b_ready : a_ready;
      @(posedge clk);
      if (rdy && !flush) got = 1'b1;
      #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (got) model_push(sel, v);
    else     check_val("send_timeout", 0, 1);
  endtask

  task automatic wait_drain(input bit sel);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 200 && (sel ? (qb.size() != 0 || b_busy) : (qa.size() != 0 || a_busy)));
    if (!sel) check_val("a_drain", (qa.size() == 0 && !a_busy), 1);
    else      check_val("b_drain", (qb.size() == 0 && !b_busy), 1);
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (rst_n && a_addr_valid) begin
      if (addr_ready && !flush) begin
        if (qa.size() == 0) check_val("a_extra_beat", 1, 0);
        else begin
          e = qa.pop_front();
          $display("beat A addr=%0d last=%0b", a_addr, a_last);
          check_val("a_addr", a_addr, e >> 1);
          check_val("a_last", a_last, e & 1);
        end
      end
      check_val("a_count", a_cnt, cnt_a);
    end
    if (rst_n && b_addr_valid) begin
      if (addr_ready && !flush) begin
        if (qb.size() == 0) check_val("b_extra_beat", 1, 0);
        else begin
          e = qb.pop_front();
          $display("beat B addr=%0d last=%0b", b_addr, b_last);
          check_val("b_addr", b_addr, e >> 1);
          check_val("b_last", b_last, e & 1);
        end
      end
      check_val("b_count", b_cnt, cnt_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    rst_n = 1'b0; flush = 1'b0; addr_ready = 1'b1;
    a_valid = 1'b0; a_vec = '0; b_valid = 1'b0; b_vec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_a_ready", a_ready, 1);
    check_val("rst_a_valid", a_addr_valid, 0);
    check_val("rst_a_last", a_last, 0);
    check_val("rst_a_busy", a_busy, 0);
    check_val("rst_a_addr", a_addr, 0);
    check_val("rst_a_nomatch", a_nomatch, 0);
    check_val("rst_a_cnt", a_cnt, 0);
    check_val("rst_b_ready", b_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 0x8011: 15,4,0 then ready again at t+4
    @(posedge clk); #1;
    send(0, 16'h8011);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_val("t8011_ready_low", a_ready, 0);
      check_val("t8011_busy", a_busy, 1);
    end
    @(negedge clk);
    check_val("t8011_ready_t4", a_ready, 1);
    check_val("t8011_idle_t4", a_busy, 0);

    // zero vector
    @(posedge clk); #1;
    send(0, 16'h0000);
    @(negedge clk);
    check_val("zero_nomatch_t1", a_nomatch, 1);
    check_val("zero_valid_t1", a_addr_valid, 0);
    check_val("zero_busy_t1", a_busy, 0);
    check_val("zero_ready_t1", a_ready, 1);
    check_val("zero_cnt", a_cnt, cnt_a);
    @(negedge clk);
    check_val("zero_nomatch_t2", a_nomatch, 0);
    check_val("zero_valid_t2", a_addr_valid, 0);

    // backpressure: 9 held while addr_ready low
    @(posedge clk); #1 addr_ready = 1'b0;
    send(0, 16'h0300);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_val("stall_valid", a_addr_valid, 1);
      check_val("stall_addr", a_addr, 9);
      check_val("stall_last", a_last, 0);
    end
    @(posedge clk); #1 addr_ready = 1'b1;
    wait_drain(0);

    // flush after the first handshake
    @(posedge clk); #1;
    send(0, 16'h00F0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    qa.delete();
    cnt_a = 0;
    @(negedge clk);
    check_val("flush_valid", a_addr_valid, 0);
    check_val("flush_ready", a_ready, 1);
    check_val("flush_busy", a_busy, 0);
    check_val("flush_cnt", a_cnt, 0);
    @(posedge clk); #1;
    send(0, 16'h0001);
    wait_drain(0);

    for (int r = 0; r < 8; r++) begin
      v = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      send(0, v);
      wait_drain(0);
    end

    // HIGH-priority, non-power-of-two instance
    @(posedge clk); #1;
    send(1, 16'h0811);
    wait_drain(1);

    @(posedge clk); #1;
    send(1, 16'h0A05);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_val("arst_b_valid", b_addr_valid, 0);
    check_val("arst_b_ready", b_ready, 1);
    check_val("arst_b_busy", b_busy, 0);
    check_val("arst_b_cnt", b_cnt, 0);
    qb.delete();
    cnt_b = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("post_rst_b_valid", b_addr_valid, 0);
      check_val("post_rst_b_ready", b_ready, 1);
    end
    @(posedge clk); #1;
    send(1, 16'h0A05);
    wait_drain(1);

    for (int r = 0; r < 6; r++) begin
      v = 16'($urandom_range(0, 4095));
      @(posedge clk); #1;
      send(1, v);
      wait_drain(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
